uart_tx_word_arbiter: RTL and testbench
=======================================

Name: uart_tx_word_arbiter

Overview:
- Shares one UART_tx_interface byte transmitter between N_REQ requesters, e.g. the debug unit's register dump, memory dump and PC report.
- Each requester presents a WORD_BYTES-byte word.
- The block arbitrates round-robin, latches the winning word, and sequences it into the transmitter one byte at a time, LSB byte first, using the transmitter's ready/done handshake.
- It pulses a per-requester completion strobe when the whole word has left the line.

Parameters:
- N_REQ, 2, number of requesters (at least 1).
- WORD_BYTES, 4, bytes per word (at least 1).
- DATA_BITS, 8, byte width; must match the transmitter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  N_REQ  level request per requester; held until that requester's o_done.
- i_word  in  N_REQ*WORD_BYTES*DATA_BITS  flattened words; requester k occupies slice k.
- o_grant  out  N_REQ  one-hot; owner of the current transfer, 0 when idle.
- o_done  out  N_REQ  one-cycle pulse on the owner's bit when its last byte completes.
- o_busy  out  1  high from grant until o_done inclusive.
- o_tx_ready  out  1  to transmitter i_ready.
- o_tx_data  out  DATA_BITS  to transmitter i_data.
- i_tx_done  in  1  from transmitter o_uart_tx_done; 1 = transmitter idle.

Behaviour:
- Clocking and reset:
  - Single clock domain; all outputs are registered.
  - Reset is asynchronous and active-high.
  - Reset values: o_grant=0, o_done=0, o_busy=0, o_tx_ready=0, o_tx_data=0, state=IDLE, byte counter=0, round-robin pointer=0 (requester 0 highest priority).
- IDLE:
  - If any i_req bit is set, pick the first set bit searching from the pointer upward, with wrap-around.
  - Latch that requester's word into the shift register and set o_grant, o_busy=1, byte counter=0. Go to SEND.
  - Latency: request sampled in cycle n; o_grant, o_busy and o_tx_ready are all high in cycle n+1.
- SEND:
  - o_tx_ready=1; o_tx_data = low DATA_BITS of the shift register.
  - Stay until i_tx_done=0, meaning the transmitter has started the frame. Then drive o_tx_ready=0 and go to WAIT.
  - The transmitter only advances on baud ticks, so this can take up to CLK_FREQ/BAUD_RATE cycles.
- WAIT:
  - Stay until i_tx_done=1.
  - If the byte counter equals WORD_BYTES-1, go to DONE.
  - Otherwise shift the register right by DATA_BITS, increment the counter, and go to SEND.
- DONE (one cycle):
  - o_done = o_grant for this cycle.
  - Pointer = granted index + 1, modulo N_REQ.
  - Next cycle: o_grant=0, o_busy=0, state=IDLE.
  - A new grant is possible in the cycle after IDLE is re-entered.
- The latched word is immune to changes on i_word after grant.
- Dropping i_req mid-transfer does not abort: the word completes and o_done still pulses.
- Simultaneous requests are resolved by the pointer only. Rotation guarantees no starvation: every requester waits at most N_REQ-1 words.
- With N_REQ=1, the grant is always requester 0.
- Entering SEND with i_tx_done already 0 (transmitter still busy from a foreign source) is legal: the block waits for the low-then-high sequence to be seen from WAIT.
  - Note: it proceeds to WAIT immediately, then waits for high, and re-enters nothing. The byte is counted only on the rising completion.
- Reset mid-operation:
  - All outputs and state return to reset values immediately; no o_done is issued.
  - The partial word is discarded and not resumed.
  - The byte already inside the transmitter is that block's concern.
- o_tx_ready is never high in IDLE, WAIT or DONE.

Test Plan:
- Single word: i_req=01, word0=0x44332211, transmitter model with done low for 20 cycles per byte → bytes 0x11, 0x22, 0x33, 0x44 in order; o_done=01 for exactly one cycle; o_busy low the next cycle.
- Contention: i_req=11 held after reset → requester 0 served first, then requester 1, then requester 0 again. o_grant sequence 01, 10, 01; no overlap of o_tx_ready across words.
- Latency and handshake: request at cycle 5 → o_tx_ready=1 at cycle 6. Transmitter holds done high for 300 cycles → o_tx_ready stays high and o_tx_data stays stable until done falls; o_tx_ready then drops within 1 cycle.
- Word change and request drop: change word0 to 0xDEADBEEF and deassert i_req after byte 1 → remaining bytes are still 0x33, 0x44 and o_done pulses.
- Reset mid-word: assert reset during byte 2 → o_tx_ready, o_grant and o_busy are 0 asynchronously. After release with i_req=10 → requester 1 is granted and byte 0 of word1 is sent.
- Parameter sweep: N_REQ=3, WORD_BYTES=1, all three requesting → grants 001, 010, 100 with one byte each.

Source files
------------

// File: rtl/uart_tx_word_arbiter.sv
// Round-robin arbiter that shares one UART byte transmitter between N_REQ
// requesters. The winning word is latched and sent LSB byte first using the
// transmitter's ready/done handshake; a completion strobe goes back to the owner.
module uart_tx_word_arbiter #(
  parameter int N_REQ      = 2,
  parameter int WORD_BYTES = 4,
  parameter int DATA_BITS  = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_REQ-1:0]                    i_req,
  input  logic [N_REQ*WORD_BYTES*DATA_BITS-1:0] i_word,
  output logic [N_REQ-1:0]                    o_grant,
  output logic [N_REQ-1:0]                    o_done,
  output logic                                o_busy,
  output logic                                o_tx_ready,
  output logic [DATA_BITS-1:0]                o_tx_data,
  input  logic                                i_tx_done
);

  localparam int WW = WORD_BYTES * DATA_BITS;
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [N_REQ-1:0] ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state, w_state;
  logic [N_REQ-1:0] r_grant, w_grant;
  logic [N_REQ-1:0] r_done, w_done;
  logic             r_busy, w_busy;
  logic             r_tx_ready, w_tx_ready;
  logic [WW-1:0]    r_shift, w_shift;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [IW-1:0]    r_ptr, w_ptr;
  logic [IW-1:0]    r_idx, w_idx;

  logic             w_found;
  logic [IW-1:0]    w_sel;

  // Round-robin search: first requesting index at or above the pointer, wrapping.
  always_comb begin
    int unsigned j;
    j       = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!w_found && i_req[IW'(j)]) begin
        w_found = 1'b1;
        w_sel   = IW'(j);
      end
    end
  end

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    w_state    = r_state;
    w_grant    = r_grant;
    w_done     = '0;
    w_busy     = r_busy;
    w_tx_ready = 1'b0;
    w_shift    = r_shift;
    w_cnt      = r_cnt;
    w_ptr      = r_ptr;
    w_idx      = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_shift    = i_word[w_sel*WW +: WW];
          w_grant    = ONE << w_sel;
          w_idx      = w_sel;
          w_busy     = 1'b1;
          w_cnt      = '0;
          w_tx_ready = 1'b1;
          w_state    = S_SEND;
        end
      end
      S_SEND: begin
        // Low done means the transmitter has taken the byte (or was already busy).
        if (!i_tx_done) begin
          w_state = S_WAIT;
        end else begin
          w_tx_ready = 1'b1;
        end
      end
      S_WAIT: begin
        if (i_tx_done) begin
          if (r_cnt == CW'(WORD_BYTES - 1)) begin
            w_done  = r_grant;
            w_state = S_DONE;
          end else begin
            w_shift    = r_shift >> DATA_BITS;
            w_cnt      = r_cnt + 1'b1;
            w_tx_ready = 1'b1;
            w_state    = S_SEND;
          end
        end
      end
      S_DONE: begin
        w_ptr   = (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
        w_grant = '0;
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_done     <= '0;
      r_busy     <= 1'b0;
      r_tx_ready <= 1'b0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_idx      <= '0;
    end else begin
      r_state    <= w_state;
      r_grant    <= w_grant;
      r_done     <= w_done;
      r_busy     <= w_busy;
      r_tx_ready <= w_tx_ready;
      r_shift    <= w_shift;
      r_cnt      <= w_cnt;
      r_ptr      <= w_ptr;
      r_idx      <= w_idx;
    end
  end

  assign o_grant    = r_grant;
  assign o_done     = r_done;
  assign o_busy     = r_busy;
  assign o_tx_ready = r_tx_ready;
  assign o_tx_data  = r_shift[DATA_BITS-1:0];

endmodule

// File: tb/tb_uart_tx_word_arbiter.sv
// Directed + randomized bench for uart_tx_word_arbiter: a default instance
// (2 requesters, 4-byte words) and a 3-requester, 1-byte instance, both
// driven by a handshake-level transmitter model and a round-robin reference.
module tb_uart_tx_word_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic tx_done;

  logic [1:0]  a_req;
  logic [63:0] a_word;
  logic [1:0]  a_grant, a_done;
  logic        a_busy, a_rdy;
  logic [7:0]  a_data;

  logic [2:0]  b_req;
  logic [23:0] b_word;
  logic [2:0]  b_grant, b_done;
  logic        b_busy, b_rdy;
  logic [7:0]  b_data;

  logic        sel_b;
  logic [2:0]  grant, done;
  logic        busy, rdy;
  logic [7:0]  data;

  int checks   = 0;
  int failures = 0;
  int a_ptr    = 0;
  int b_ptr    = 0;

  always #5 clk = ~clk;

  uart_tx_word_arbiter #(.N_REQ(2), .WORD_BYTES(4), .DATA_BITS(8)) dut_a (
    .clk(clk), .reset(rst), .i_req(a_req), .i_word(a_word),
    .o_grant(a_grant), .o_done(a_done), .o_busy(a_busy),
    .o_tx_ready(a_rdy), .o_tx_data(a_data), .i_tx_done(tx_done)
  );

  uart_tx_word_arbiter #(.N_REQ(3), .WORD_BYTES(1), .DATA_BITS(8)) dut_b (
    .clk(clk), .reset(rst), .i_req(b_req), .i_word(b_word),
    .o_grant(b_grant), .o_done(b_done), .o_busy(b_busy),
    .o_tx_ready(b_rdy), .o_tx_data(b_data), .i_tx_done(tx_done)
  );

  assign grant = sel_b ? b_grant : {1'b0, a_grant};
  assign done  = sel_b ? b_done  : {1'b0, a_done};
  assign busy  = sel_b ? b_busy  : a_busy;
  assign rdy   = sel_b ? b_rdy   : a_rdy;
  assign data  = sel_b ? b_data  : a_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference round robin: first requester at or after ptr, wrapping.
  function automatic int rr_pick(input int ptr, input int mask, input int n);
    for (int k = 0; k < n; k++) begin
      int j;
      j = (ptr + k) % n;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  // Transmitter model for one byte: accept when ready, optionally stall with
  // done high for 'pre' cycles, then hold done low for 'len' cycles.
  task automatic serve(input int pre, input int len, input bit chk_hold, output logic [7:0] b);
    int n;
    bit stable;
    n = 0;
    stable = 1'b1;
    while (rdy !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("ready_wait", rdy, 1);
    b = data;
    for (int i = 0; i < pre; i++) begin
      tick();
      if (rdy !== 1'b1 || data !== b) stable = 1'b0;
    end
    if (chk_hold) chk("ready_data_hold", stable, 1);
    tx_done = 1'b0;
    tick();
    chk("ready_drop", rdy, 0);
    for (int i = 1; i < len; i++) tick();
    tx_done = 1'b1;
  endtask

  // One full word: grant one cycle after the call, bytes LSB first, done pulse.
  task automatic xfer(input int idx, input int nb, input logic [31:0] w,
                      input int pre0, input int flen, input bit mod);
    logic [7:0] b;
    int len;
    tick();
    chk("grant", grant, 1 << idx);
    chk("busy_on_grant", busy, 1);
    chk("ready_latency", rdy, 1);
    for (int i = 0; i < nb; i++) begin
      len = (flen > 0) ? flen : int'($urandom_range(25, 1));
      serve((i == 0) ? pre0 : int'($urandom_range(3, 0)), len, (i == 0) && (pre0 > 0), b);
      chk("byte", b, (w >> (8 * i)) & 32'hFF);
      if (mod && i == 1) begin
        a_word[31:0] = 32'hDEADBEEF;
        a_req = 2'b00;
      end
    end
    tick();
    chk("done_pulse", done, 1 << idx);
    chk("busy_in_done", busy, 1);
    tick();
    chk("done_clear", done, 0);
    chk("grant_clear", grant, 0);
    chk("busy_clear", busy, 0);
  endtask

  initial begin
    int idx, mask;
    logic [7:0] b;
    int n;
    rst = 1'b1;
    tx_done = 1'b1;
    a_req = '0; a_word = '0;
    b_req = '0; b_word = '0;
    sel_b = 1'b0;
    tick(); tick();
    chk("rst_grant", a_grant, 0);
    chk("rst_done", a_done, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ready", a_rdy, 0);
    chk("rst_data", a_data, 0);
    rst = 1'b0;

    // Single word, 20-cycle frames.
    a_req = 2'b01;
    a_word[31:0] = 32'h44332211;
    idx = rr_pick(a_ptr, 1, 2);
    xfer(idx, 4, 32'h44332211, 0, 20, 1'b0);
    a_ptr = (idx + 1) % 2;

    // Contention from a fresh reset: 0, 1, 0.
    a_req = 2'b00;
    rst = 1'b1; tick(); rst = 1'b0;
    a_ptr = 0;
    a_req = 2'b11;
    a_word = {$urandom, $urandom};
    for (int r = 0; r < 3; r++) begin
      idx = rr_pick(a_ptr, 3, 2);
      xfer(idx, 4, a_word[idx*32 +: 32], 0, 0, 1'b0);
      a_ptr = (idx + 1) % 2;
    end

    // Transmitter stalls with done high for 300 cycles on the first byte.
    a_req = 2'b01;
    a_word[31:0] = $urandom;
    idx = rr_pick(a_ptr, 1, 2);
    xfer(idx, 4, a_word[31:0], 300, 0, 1'b0);
    a_ptr = (idx + 1) % 2;

    // Word change and request drop after byte 1 must not disturb the transfer.
    a_req = 2'b01;
    a_word[31:0] = 32'h44332211;
    idx = rr_pick(a_ptr, 1, 2);
    xfer(idx, 4, 32'h44332211, 0, 0, 1'b1);
    a_ptr = (idx + 1) % 2;

    // Randomized request masks and words.
    for (int r = 0; r < 6; r++) begin
      mask = int'($urandom_range(3, 1));
      a_req = mask[1:0];
      a_word = {$urandom, $urandom};
      idx = rr_pick(a_ptr, mask, 2);
      xfer(idx, 4, a_word[idx*32 +: 32], 0, 0, 1'b0);
      a_ptr = (idx + 1) % 2;
    end

    // Reset while byte 2 is being offered.
    a_req = 2'b01;
    a_word = {$urandom, $urandom};
    tick();
    chk("mid_grant", a_grant, 1);
    serve(0, 5, 1'b0, b);
    serve(0, 5, 1'b0, b);
    n = 0;
    while (a_rdy !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("mid_ready", a_rdy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_ready", a_rdy, 0);
    chk("async_grant", a_grant, 0);
    chk("async_busy", a_busy, 0);
    chk("async_done", a_done, 0);
    tick(); tick();
    a_req = 2'b10;
    rst = 1'b0;
    a_ptr = 0;
    idx = rr_pick(a_ptr, 2, 2);
    xfer(idx, 4, a_word[idx*32 +: 32], 0, 0, 1'b0);
    a_ptr = (idx + 1) % 2;
    a_req = 2'b00;
    tick();

    // Three requesters, one byte each.
    sel_b = 1'b1;
    b_req = 3'b111;
    b_word = $urandom;
    for (int r = 0; r < 3; r++) begin
      idx = rr_pick(b_ptr, 7, 3);
      xfer(idx, 1, 32'(b_word[idx*8 +: 8]), 0, 0, 1'b0);
      b_ptr = (idx + 1) % 3;
    end
    b_req = 3'b000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
